// File: rtl/dmem_access_ctrl_if.sv
// Bundle of MEM-stage request, pipeline-stall, data-memory port and load-result
// signals for the data-memory access controller.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_ld_op;
  logic [2:0]  req_st_op;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall_mem;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        ld_valid;
  logic [31:0] ld_rdata;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_op;
  logic        misalign_fault;

  // Handshake: a request is offered while req_valid is high and is held until
  // stall_mem drops; a memory strobe stays high until a dmem_resp pulse.
  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_ld_op, req_st_op,
           req_wdata, flush, dmem_resp, dmem_rdata,
    output stall_mem, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
           ld_valid, ld_rdata, ld_offset, ld_op, misalign_fault
  );

  modport master (
    output req_valid, req_read, req_write, req_addr, req_ld_op, req_st_op,
           req_wdata, flush, dmem_resp, dmem_rdata,
    input  stall_mem, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
           ld_valid, ld_rdata, ld_offset, ld_op, misalign_fault
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check, one word-aligned
// memory transaction per load/store, pipeline stall until the response returns.
module dmem_access_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  dmem_access_ctrl_if.slave   bus,
  output logic [1:0]          state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic        write_q, write_d;
  logic        fault_q, fault_d;
  logic        squash_q, squash_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;
  logic [1:0]  ld_offset_q, ld_offset_d;
  logic [2:0]  ld_op_q, ld_op_d;

  logic        access_req;
  logic [2:0]  req_op;
  logic        misaligned;

  assign access_req = bus.req_valid & (bus.req_read | bus.req_write) & ~bus.flush;
  assign req_op     = bus.req_write ? bus.req_st_op : bus.req_ld_op;

  // Halfword codes share 001 for loads and stores; 101 is only lhu.
  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      3'b001:  misaligned = bus.req_addr[0];
      3'b101:  misaligned = bus.req_read & bus.req_addr[0];
      3'b010:  misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= '0;
      write_q     <= 1'b0;
      fault_q     <= 1'b0;
      squash_q    <= 1'b0;
      ld_rdata_q  <= '0;
      ld_offset_q <= '0;
      ld_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      write_q     <= write_d;
      fault_q     <= fault_d;
      squash_q    <= squash_d;
      ld_rdata_q  <= ld_rdata_d;
      ld_offset_q <= ld_offset_d;
      ld_op_q     <= ld_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    write_d     = write_q;
    fault_d     = fault_q;
    squash_d    = squash_q;
    ld_rdata_d  = ld_rdata_q;
    ld_offset_d = ld_offset_q;
    ld_op_d     = ld_op_q;
    case (state_q)
      IDLE: begin
        if (access_req && misaligned) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else if (access_req) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          op_d     = req_op;
          write_d  = bus.req_write;
          fault_d  = 1'b0;
          squash_d = 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // A flush cannot abandon the bus transaction; it only hides the result.
        if (bus.flush) squash_d = 1'b1;
        if (bus.dmem_resp) begin
          if (!write_q) begin
            ld_rdata_d  = bus.dmem_rdata;
            ld_offset_d = addr_q[1:0];
            ld_op_d     = op_q;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_access;
  logic in_done;

  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  always_comb begin
    bus.dmem_mbe   = 4'b0000;
    bus.dmem_wdata = wdata_q;
    if (write_q) begin
      case (op_q)
        3'b000: begin
          bus.dmem_wdata = {4{wdata_q[7:0]}};
          if (in_access) bus.dmem_mbe = 4'b0001 << addr_q[1:0];
        end
        3'b001: begin
          bus.dmem_wdata = {2{wdata_q[15:0]}};
          if (in_access) bus.dmem_mbe = 4'b0011 << addr_q[1:0];
        end
        3'b010: begin
          bus.dmem_wdata = wdata_q;
          if (in_access) bus.dmem_mbe = 4'b1111;
        end
        default: bus.dmem_mbe = 4'b0000;
      endcase
    end else if (in_access) begin
      bus.dmem_mbe = 4'b1111;
    end
  end

  assign bus.stall_mem      = ((state_q == IDLE) & access_req) | in_access;
  assign bus.dmem_read      = in_access & ~write_q;
  assign bus.dmem_write     = in_access & write_q;
  assign bus.dmem_addr      = {addr_q[31:2], 2'b00};
  assign bus.ld_valid       = in_done & ~write_q & ~fault_q & ~squash_q & ~bus.flush;
  assign bus.misalign_fault = in_done & fault_q & ~bus.flush;
  assign bus.ld_rdata       = ld_rdata_q;
  assign bus.ld_offset      = ld_offset_q;
  assign bus.ld_op          = ld_op_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, misalignment, flush,
// mid-access reset and back-to-back accesses with hand-computed expectations.
module tb_dmem_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic idle_in();
    bus.req_valid  = 1'b0;
    bus.req_read   = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_ld_op  = '0;
    bus.req_st_op  = '0;
    bus.req_wdata  = '0;
    bus.flush      = 1'b0;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = '0;
  endtask

  task automatic req_ld(input logic [31:0] addr, input logic [2:0] op);
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.req_ld_op = op;
  endtask

  task automatic req_st(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_st_op = op;
    bus.req_wdata = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_in();
    rst_n = 1'b0;

    // Reset state
    cyc(); look();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_stall", 32'(bus.stall_mem), 32'd0);
    chk("rst_read", 32'(bus.dmem_read), 32'd0);
    chk("rst_write", 32'(bus.dmem_write), 32'd0);
    chk("rst_mbe", 32'(bus.dmem_mbe), 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_ldv", 32'(bus.ld_valid), 32'd0);
    chk("rst_fault", 32'(bus.misalign_fault), 32'd0);
    cyc(); rst_n = 1'b1;

    // lw with two wait cycles
    cyc(); req_ld(32'h1000_0004, 3'b010); look();
    chk("lw_acc_stall", 32'(bus.stall_mem), 32'd1);
    chk("lw_acc_read", 32'(bus.dmem_read), 32'd0);
    cyc(); look();
    chk("lw_a1_state", 32'(state_dbg), 32'd1);
    chk("lw_a1_read", 32'(bus.dmem_read), 32'd1);
    chk("lw_a1_addr", bus.dmem_addr, 32'h1000_0004);
    chk("lw_a1_mbe", 32'(bus.dmem_mbe), 32'hF);
    chk("lw_a1_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); look();
    chk("lw_a2_read", 32'(bus.dmem_read), 32'd1);
    cyc(); bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF; look();
    chk("lw_a3_read", 32'(bus.dmem_read), 32'd1);
    chk("lw_a3_ldv", 32'(bus.ld_valid), 32'd0);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("lw_done_state", 32'(state_dbg), 32'd2);
    chk("lw_done_ldv", 32'(bus.ld_valid), 32'd1);
    chk("lw_done_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
    chk("lw_done_off", 32'(bus.ld_offset), 32'd0);
    chk("lw_done_op", 32'(bus.ld_op), 32'd2);
    chk("lw_done_stall", 32'(bus.stall_mem), 32'd0);
    chk("lw_done_read", 32'(bus.dmem_read), 32'd0);
    cyc(); idle_in(); look();
    chk("lw_after_ldv", 32'(bus.ld_valid), 32'd0);
    chk("lw_after_state", 32'(state_dbg), 32'd0);
    chk("lw_after_hold", bus.ld_rdata, 32'hDEAD_BEEF);

    // sb at offset 3
    cyc(); req_st(32'h2000_0003, 3'b000, 32'h0000_00A5); look();
    chk("sb_acc_stall", 32'(bus.stall_mem), 32'd1);
    chk("sb_acc_write", 32'(bus.dmem_write), 32'd0);
    cyc(); bus.dmem_resp = 1'b1; look();
    chk("sb_write", 32'(bus.dmem_write), 32'd1);
    chk("sb_read", 32'(bus.dmem_read), 32'd0);
    chk("sb_mbe", 32'(bus.dmem_mbe), 32'h8);
    chk("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", bus.dmem_addr, 32'h2000_0000);
    cyc(); bus.dmem_resp = 1'b0; look();
    chk("sb_done_state", 32'(state_dbg), 32'd2);
    chk("sb_done_ldv", 32'(bus.ld_valid), 32'd0);
    chk("sb_done_write", 32'(bus.dmem_write), 32'd0);
    chk("sb_done_stall", 32'(bus.stall_mem), 32'd0);

    // sh at offset 2, accepted in the cycle right after DONE
    cyc(); idle_in(); req_st(32'h2000_0002, 3'b001, 32'h0000_1234); look();
    chk("sh_acc_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.dmem_resp = 1'b1; look();
    chk("sh_mbe", 32'(bus.dmem_mbe), 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'h1234_1234);
    cyc(); bus.dmem_resp = 1'b0; look();
    chk("sh_done_state", 32'(state_dbg), 32'd2);
    chk("sh_done_ldv", 32'(bus.ld_valid), 32'd0);

    // Misaligned lh at offset 1
    cyc(); idle_in(); req_ld(32'h3000_0001, 3'b001); look();
    chk("lh_mis_stall", 32'(bus.stall_mem), 32'd1);
    chk("lh_mis_read", 32'(bus.dmem_read), 32'd0);
    cyc(); look();
    chk("lh_mis_state", 32'(state_dbg), 32'd2);
    chk("lh_mis_fault", 32'(bus.misalign_fault), 32'd1);
    chk("lh_mis_read2", 32'(bus.dmem_read), 32'd0);
    chk("lh_mis_stall2", 32'(bus.stall_mem), 32'd0);
    chk("lh_mis_ldv", 32'(bus.ld_valid), 32'd0);

    // Misaligned sw at offset 2
    cyc(); idle_in(); req_st(32'h3000_0002, 3'b010, 32'hFFFF_FFFF); look();
    chk("sw_mis_fault0", 32'(bus.misalign_fault), 32'd0);
    chk("sw_mis_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); look();
    chk("sw_mis_fault", 32'(bus.misalign_fault), 32'd1);
    chk("sw_mis_write", 32'(bus.dmem_write), 32'd0);
    chk("sw_mis_stall2", 32'(bus.stall_mem), 32'd0);

    // lb at offset 3 is a normal access
    cyc(); idle_in(); req_ld(32'h3000_0003, 3'b000); look();
    chk("lb_acc_stall", 32'(bus.stall_mem), 32'd1);
    chk("lb_acc_fault", 32'(bus.misalign_fault), 32'd0);
    cyc(); bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1122_3344; look();
    chk("lb_read", 32'(bus.dmem_read), 32'd1);
    chk("lb_mbe", 32'(bus.dmem_mbe), 32'hF);
    chk("lb_addr", bus.dmem_addr, 32'h3000_0000);
    cyc(); bus.dmem_resp = 1'b0; look();
    chk("lb_ldv", 32'(bus.ld_valid), 32'd1);
    chk("lb_off", 32'(bus.ld_offset), 32'd3);
    chk("lb_op", 32'(bus.ld_op), 32'd0);
    chk("lb_rdata", bus.ld_rdata, 32'h1122_3344);

    // Flush during ACCESS of lbu
    cyc(); idle_in(); req_ld(32'h4000_0001, 3'b100); look();
    chk("lbu_acc_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.flush = 1'b1; look();
    chk("lbu_fl_state", 32'(state_dbg), 32'd1);
    chk("lbu_fl_read", 32'(bus.dmem_read), 32'd1);
    chk("lbu_fl_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.flush = 1'b0; bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0000_FF00; look();
    chk("lbu_resp_read", 32'(bus.dmem_read), 32'd1);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("lbu_done_state", 32'(state_dbg), 32'd2);
    chk("lbu_done_ldv", 32'(bus.ld_valid), 32'd0);
    chk("lbu_done_rdata", bus.ld_rdata, 32'h0000_FF00);
    chk("lbu_done_off", 32'(bus.ld_offset), 32'd1);
    chk("lbu_done_op", 32'(bus.ld_op), 32'd4);

    // Flush in IDLE ignores the request
    cyc(); idle_in(); req_ld(32'h4000_0000, 3'b010); bus.flush = 1'b1; look();
    chk("flidle_stall", 32'(bus.stall_mem), 32'd0);
    chk("flidle_read", 32'(bus.dmem_read), 32'd0);
    cyc(); look();
    chk("flidle_state", 32'(state_dbg), 32'd0);
    chk("flidle_read2", 32'(bus.dmem_read), 32'd0);

    // Misaligned lw whose DONE is flushed: no fault pulse
    cyc(); bus.flush = 1'b0; req_ld(32'h4000_0003, 3'b010); look();
    chk("mfl_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.flush = 1'b1; look();
    chk("mfl_state", 32'(state_dbg), 32'd2);
    chk("mfl_fault", 32'(bus.misalign_fault), 32'd0);

    // Reset asserted mid-ACCESS
    cyc(); idle_in(); req_ld(32'h5000_0008, 3'b010); look();
    chk("rma_acc_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); look();
    chk("rma_read", 32'(bus.dmem_read), 32'd1);
    idle_in(); rst_n = 1'b0; #1;
    chk("rma_read0", 32'(bus.dmem_read), 32'd0);
    chk("rma_state0", 32'(state_dbg), 32'd0);
    chk("rma_addr0", bus.dmem_addr, 32'd0);
    chk("rma_stall0", 32'(bus.stall_mem), 32'd0);
    chk("rma_rdata0", bus.ld_rdata, 32'd0);
    chk("rma_off0", 32'(bus.ld_offset), 32'd0);
    chk("rma_op0", 32'(bus.ld_op), 32'd0);
    cyc(); rst_n = 1'b1; bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h9999_9999; look();
    chk("late_read", 32'(bus.dmem_read), 32'd0);
    chk("late_state", 32'(state_dbg), 32'd0);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("late_ldv", 32'(bus.ld_valid), 32'd0);
    chk("late_rdata", bus.ld_rdata, 32'd0);
    cyc(); req_ld(32'h5000_0008, 3'b010); look();
    chk("rlw_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D; look();
    chk("rlw_read", 32'(bus.dmem_read), 32'd1);
    chk("rlw_addr", bus.dmem_addr, 32'h5000_0008);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("rlw_ldv", 32'(bus.ld_valid), 32'd1);
    chk("rlw_rdata", bus.ld_rdata, 32'hCAFE_F00D);

    // Back-to-back loads with same-cycle responses
    cyc(); idle_in(); req_ld(32'h6000_0000, 3'b010); look();
    chk("b1_acc_state", 32'(state_dbg), 32'd0);
    chk("b1_acc_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0101_0101; look();
    chk("b1_access", 32'(state_dbg), 32'd1);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("b1_done", 32'(state_dbg), 32'd2);
    chk("b1_ldv", 32'(bus.ld_valid), 32'd1);
    chk("b1_rdata", bus.ld_rdata, 32'h0101_0101);
    cyc(); req_ld(32'h6000_0004, 3'b010); look();
    chk("b2_acc_state", 32'(state_dbg), 32'd0);
    chk("b2_acc_stall", 32'(bus.stall_mem), 32'd1);
    cyc(); bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0202_0202; look();
    chk("b2_access", 32'(state_dbg), 32'd1);
    chk("b2_addr", bus.dmem_addr, 32'h6000_0004);
    cyc(); bus.dmem_resp = 1'b0; bus.dmem_rdata = '0; look();
    chk("b2_done", 32'(state_dbg), 32'd2);
    chk("b2_ldv", 32'(bus.ld_valid), 32'd1);
    chk("b2_rdata", bus.ld_rdata, 32'h0202_0202);
    chk("b2_off", 32'(bus.ld_offset), 32'd0);
    cyc(); idle_in(); look();
    chk("end_state", 32'(state_dbg), 32'd0);
    chk("end_ldv", 32'(bus.ld_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
